qspi_matmul_nxn: RTL and testbench

//  Parametrised successor of the 2x2 QSPI matrix multiplier: computes C = A x B for NxN unsigned matrices.

---
 rtl/qspi_matmul_nxn.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_qspi_matmul_nxn.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_matmul_nxn.sv
// qspi_matmul_nxn
//   Computes C = A x B for NxN unsigned matrices loaded over a 4-bit QSPI-style
//   host link. The first byte of each chip-select frame is a command:
//     0x10 load A, load B, compute, stream C
//     0x20 load B only and reuse the stored A (only if A is valid)
//     0x30 re-stream the stored C (all zero nibbles if C was never computed)
//     other: ignore the frame until cs_n rises
//   The products are formed one per clk by a single time-shared MAC.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   qspi_clk     host serial clock (async, synchronised, edges detected in clk domain)
//   qspi_cs_n    host chip select, active low (synchronised)
//   qspi_io_in   host data nibble, sampled on synchronised qspi_clk rise
//   qspi_io_out  result nibble
//   qspi_io_oe   4'hF while driving results, else 4'h0
//   busy         high from the first command nibble until the FSM returns to IDLE
//   done         one-clk pulse after the last result nibble has been sent
module qspi_matmul_nxn #(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW + $clog2(N)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       qspi_clk,
  input  logic       qspi_cs_n,
  input  logic [3:0] qspi_io_in,
  output logic [3:0] qspi_io_out,
  output logic [3:0] qspi_io_oe,
  output logic       busy,
  output logic       done
);

  localparam int EN    = DW / 4;
  localparam int NIB_R = (ACC_W + 3) / 4;
  localparam int NN    = N * N;
  localparam int N3    = N * N * N;
  localparam int PW    = NIB_R * 4;
  localparam int MW    = 2 * DW;
  localparam int NC_W  = (EN > 1) ? $clog2(EN) : 1;
  localparam int EI_W  = $clog2(NN);
  localparam int CI_W  = $clog2(N);
  localparam int CY_W  = $clog2(N3 + 1);
  localparam int ON_W  = (NIB_R > 1) ? $clog2(NIB_R) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPUTE,
    S_OUTPUT,
    S_IGNORE
  } state_t;

  state_t state, state_n;

  // synchronisers and edge detection
  logic       qclk_s1, qclk_s2, qclk_d;
  logic       cs_s1, cs_s2;
  logic [3:0] io_s1, io_s2;

  // front end
  logic [3:0]      cmd_hi;
  logic            cmd_half;
  logic [NC_W-1:0] nib_cnt;
  logic [EI_W-1:0] elem_idx;
  logic [DW-1:0]   elem_shift;
  logic            a_valid, c_valid;

  // storage
  logic [DW-1:0]    a_mem   [NN];
  logic [DW-1:0]    b_mem   [NN];
  logic [ACC_W-1:0] c_mem   [NN];
  logic [ACC_W-1:0] c_stage [NN];

  // MAC
  logic [CY_W-1:0]  cyc;
  logic [CI_W-1:0]  ci, cj, ck;
  logic             p_val, p_first, p_last;
  logic [EI_W-1:0]  p_idx;
  logic [MW-1:0]    prod;
  logic [ACC_W-1:0] acc;

  // output
  logic [EI_W-1:0] out_e;
  logic [ON_W-1:0] out_n;
  logic            out_armed;

  // combinational helpers
  logic             q_rise, q_fall, smp, abort;
  logic             elem_done, last_elem, comp_end, comp_done, issue;
  logic             out_last, out_step, done_set;
  logic [7:0]       cmd_byte;
  logic [DW-1:0]    elem_val;
  logic [EI_W-1:0]  a_sel, b_sel, c_sel;
  logic [ACC_W-1:0] acc_sum;
  logic [PW-1:0]    cur_pad;
  logic [3:0]       cur_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qclk_s1 <= 1'b0;
      qclk_s2 <= 1'b0;
      qclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      io_s1   <= '0;
      io_s2   <= '0;
    end else begin
      qclk_s1 <= qspi_clk;
      qclk_s2 <= qclk_s1;
      qclk_d  <= qclk_s2;
      cs_s1   <= qspi_cs_n;
      cs_s2   <= cs_s1;
      io_s1   <= qspi_io_in;
      io_s2   <= io_s1;
    end
  end

  always_comb begin
    q_rise    = qclk_s2 & ~qclk_d;
    q_fall    = ~qclk_s2 & qclk_d;
    smp       = q_rise & ~cs_s2;
    abort     = cs_s2 && (state != S_IDLE);
    elem_done = smp && (nib_cnt == NC_W'(EN - 1));
    last_elem = (elem_idx == EI_W'(NN - 1));
    cmd_byte  = {cmd_hi, io_s2};
    elem_val  = DW'({elem_shift, io_s2});
    comp_end  = (cyc == CY_W'(N3));
    issue     = (cyc < CY_W'(N3));
    a_sel     = EI_W'(ci) * EI_W'(N) + EI_W'(ck);
    b_sel     = EI_W'(ck) * EI_W'(N) + EI_W'(cj);
    c_sel     = EI_W'(ci) * EI_W'(N) + EI_W'(cj);
    acc_sum   = (p_first ? '0 : acc) + ACC_W'(prod);
    out_last  = (out_e == EI_W'(NN - 1)) && (out_n == ON_W'(NIB_R - 1));
    // A fall only advances after a rise has been seen in OUTPUT, so the fall
    // that trails the command/last-load nibble never skips C[0][0]'s MS nibble.
    out_step  = q_fall && out_armed;
  end

  always_comb begin
    state_n  = state;
    done_set = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (!cs_s2) state_n = S_CMD;
        S_CMD: begin
          if (smp && cmd_half) begin
            if (cmd_byte == 8'h10)                 state_n = S_LOAD_A;
            else if (cmd_byte == 8'h20 && a_valid) state_n = S_LOAD_B;
            else if (cmd_byte == 8'h30)            state_n = S_OUTPUT;
            else                                   state_n = S_IGNORE;
          end
        end
        S_LOAD_A:  if (elem_done && last_elem) state_n = S_LOAD_B;
        S_LOAD_B:  if (elem_done && last_elem) state_n = S_COMPUTE;
        S_COMPUTE: if (comp_end) state_n = S_OUTPUT;
        S_OUTPUT: begin
          if (out_step && out_last) begin
            state_n  = S_IDLE;
            done_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
    comp_done = (state == S_COMPUTE) && (state_n == S_OUTPUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_hi     <= '0;
      cmd_half   <= 1'b0;
      nib_cnt    <= '0;
      elem_idx   <= '0;
      elem_shift <= '0;
      a_valid    <= 1'b0;
      c_valid    <= 1'b0;
      for (int unsigned e = 0; e < NN; e++) begin
        a_mem[e]   <= '0;
        b_mem[e]   <= '0;
        c_mem[e]   <= '0;
        c_stage[e] <= '0;
      end
      cyc       <= '0;
      ci        <= '0;
      cj        <= '0;
      ck        <= '0;
      p_val     <= 1'b0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
      p_idx     <= '0;
      prod      <= '0;
      acc       <= '0;
      out_e     <= '0;
      out_n     <= '0;
      out_armed <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_set;

      // Any state change (including abort) discards partial nibble/element progress.
      if (state_n != state) begin
        cmd_half   <= 1'b0;
        nib_cnt    <= '0;
        elem_idx   <= '0;
        elem_shift <= '0;
      end else if (smp) begin
        if (state == S_CMD) begin
          cmd_hi   <= io_s2;
          cmd_half <= 1'b1;
        end else if (state == S_LOAD_A || state == S_LOAD_B) begin
          if (nib_cnt == NC_W'(EN - 1)) begin
            nib_cnt    <= '0;
            elem_shift <= '0;
            elem_idx   <= elem_idx + EI_W'(1);
          end else begin
            nib_cnt    <= nib_cnt + NC_W'(1);
            elem_shift <= elem_val;
          end
        end
      end

      if (state == S_LOAD_A && elem_done) a_mem[elem_idx] <= elem_val;
      if (state == S_LOAD_B && elem_done) b_mem[elem_idx] <= elem_val;

      if (state == S_LOAD_A) begin
        if (abort)                       a_valid <= 1'b0;
        else if (elem_done && last_elem) a_valid <= 1'b1;
      end

      // Two-stage MAC: multiply in stage 1, accumulate in stage 2. Results go to
      // c_stage and are copied to c_mem only on completion, so an aborted
      // compute leaves the previous C intact.
      if (state != S_COMPUTE) begin
        cyc   <= '0;
        ci    <= '0;
        cj    <= '0;
        ck    <= '0;
        p_val <= 1'b0;
      end else begin
        cyc   <= cyc + CY_W'(1);
        p_val <= issue;
        if (issue) begin
          prod    <= MW'(a_mem[a_sel]) * MW'(b_mem[b_sel]);
          p_first <= (ck == '0);
          p_last  <= (ck == CI_W'(N - 1));
          p_idx   <= c_sel;
          if (ck == CI_W'(N - 1)) begin
            ck <= '0;
            if (cj == CI_W'(N - 1)) begin
              cj <= '0;
              ci <= ci + CI_W'(1);
            end else begin
              cj <= cj + CI_W'(1);
            end
          end else begin
            ck <= ck + CI_W'(1);
          end
        end
        if (p_val) begin
          acc <= acc_sum;
          if (p_last) c_stage[p_idx] <= acc_sum;
        end
        if (comp_done) begin
          for (int unsigned e = 0; e < NN; e++)
            c_mem[e] <= (EI_W'(e) == p_idx) ? acc_sum : c_stage[e];
          c_valid <= 1'b1;
        end
      end

      if (state != S_OUTPUT) begin
        out_e     <= '0;
        out_n     <= '0;
        out_armed <= 1'b0;
      end else if (smp) begin
        out_armed <= 1'b1;
      end else if (out_step && !out_last) begin
        out_armed <= 1'b0;
        if (out_n == ON_W'(NIB_R - 1)) begin
          out_n <= '0;
          out_e <= out_e + EI_W'(1);
        end else begin
          out_n <= out_n + ON_W'(1);
        end
      end
    end
  end

  always_comb begin
    cur_pad = c_valid ? PW'(c_mem[out_e]) : '0;
    cur_nib = '0;
    for (int unsigned n = 0; n < NIB_R; n++)
      if (out_n == ON_W'(n)) cur_nib = cur_pad[(NIB_R - 1 - n) * 4 +: 4];
  end

  assign qspi_io_oe  = (state == S_OUTPUT && !cs_s2) ? 4'hF : 4'h0;
  assign qspi_io_out = (state == S_OUTPUT && !cs_s2) ? cur_nib : 4'h0;
  assign busy        = (state != S_IDLE) && !(state == S_CMD && !cmd_half);

endmodule

// File: tb/tb_qspi_matmul_nxn.sv
// Testbench for qspi_matmul_nxn: one 2x2/8-bit instance and one 3x3/4-bit
// instance, directed host transactions, expected result nibbles queued from a
// reference matrix product and popped as the DUT streams them.
module tb_qspi_matmul_nxn;

  logic       clk, rst_n;
  logic       qclk0, cs0, qclk1, cs1;
  logic [3:0] io0, io1;
  logic [3:0] out0, oe0, out1, oe1;
  logic       busy0, done0, busy1, done1;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;

  logic [3:0] exp_q[$];
  int ma[16];
  int mb[16];

  qspi_matmul_nxn #(.N(2), .DW(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .qspi_clk(qclk0), .qspi_cs_n(cs0),
    .qspi_io_in(io0), .qspi_io_out(out0), .qspi_io_oe(oe0),
    .busy(busy0), .done(done0)
  );

  qspi_matmul_nxn #(.N(3), .DW(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .qspi_clk(qclk1), .qspi_cs_n(cs1),
    .qspi_io_in(io1), .qspi_io_out(out1), .qspi_io_oe(oe1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_q(input int d, input logic v);
    if (d == 0) qclk0 = v; else qclk1 = v;
  endtask

  task automatic set_cs(input int d, input logic v);
    if (d == 0) cs0 = v; else cs1 = v;
  endtask

  function automatic logic [3:0] get_out(input int d);
    return (d == 0) ? out0 : out1;
  endfunction

  function automatic logic [3:0] get_oe(input int d);
    return (d == 0) ? oe0 : oe1;
  endfunction

  task automatic send_nib(input int d, input int v);
    if (d == 0) io0 = 4'(v); else io1 = 4'(v);
    wait_clk(2);
    set_q(d, 1'b1);
    wait_clk(5);
    set_q(d, 1'b0);
    wait_clk(5);
  endtask

  task automatic send_byte(input int d, input int v);
    send_nib(d, (v >> 4) & 15);
    send_nib(d, v & 15);
  endtask

  task automatic send_elem(input int d, input int v, input int en);
    for (int e = en - 1; e >= 0; e--) send_nib(d, (v >> (4 * e)) & 15);
  endtask

  task automatic send_mat(input int d, input int n, input int en, input int sel_b);
    for (int i = 0; i < n * n; i++) send_elem(d, (sel_b != 0) ? mb[i] : ma[i], en);
  endtask

  task automatic cs_low(input int d);
    set_cs(d, 1'b0);
    wait_clk(5);
  endtask

  task automatic cs_high(input int d);
    set_cs(d, 1'b1);
    wait_clk(5);
  endtask

  // reference product, pushed row-major, MS nibble first
  task automatic push_model(input int n, input int nibr);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        int c;
        c = 0;
        for (int k = 0; k < n; k++) c += ma[i * n + k] * mb[k * n + j];
        for (int nb = nibr - 1; nb >= 0; nb--) exp_q.push_back(4'((c >> (4 * nb)) & 15));
      end
  endtask

  task automatic push_zeros(input int cnt);
    for (int i = 0; i < cnt; i++) exp_q.push_back(4'h0);
  endtask

  task automatic wait_oe(input int d, input string tag);
    int t;
    t = 0;
    while (get_oe(d) != 4'hF && t < 200) begin
      wait_clk(1);
      t++;
    end
    check(tag, get_oe(d), 4'hF);
  endtask

  task automatic read_out(input int d, input int cnt, input string tag);
    int d0;
    d0 = (d == 0) ? done_cnt0 : done_cnt1;
    for (int i = 0; i < cnt; i++) begin
      logic [3:0] e;
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'(i), 32'(cnt));
        break;
      end
      e = exp_q.pop_front();
      check({tag, "_nib"}, {get_oe(d), get_out(d)}, {4'hF, e});
      set_q(d, 1'b1);
      wait_clk(5);
      set_q(d, 1'b0);
      wait_clk(6);
    end
    wait_clk(3);
    check({tag, "_done_once"}, 32'(((d == 0) ? done_cnt0 : done_cnt1) - d0), 32'd1);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    qclk0 = 1'b0; cs0 = 1'b1; io0 = 4'h0;
    qclk1 = 1'b0; cs1 = 1'b1; io1 = 4'h0;
    wait_clk(4);
    check("rst_out", 32'(out0), 32'd0);
    check("rst_oe", 32'(oe0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_oe1", 32'(oe1), 32'd0);
    rst_n = 1'b1;
    wait_clk(3);

    // replay with no computed C: all zero nibbles
    cs_low(0);
    send_byte(0, 8'h30);
    wait_oe(0, "zero_oe");
    push_zeros(20);
    read_out(0, 20, "zero_replay");
    cs_high(0);
    check("zero_busy_after", 32'(busy0), 32'd0);

    // basic 2x2 multiply, busy rises after the first command nibble
    ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
    mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
    cs_low(0);
    check("busy_pre_cmd", 32'(busy0), 32'd0);
    send_nib(0, 1);
    check("busy_first_nib", 32'(busy0), 32'd1);
    send_nib(0, 0);
    send_mat(0, 2, 2, 0);
    send_mat(0, 2, 2, 1);
    wait_oe(0, "mul_oe");
    push_model(2, 5);
    read_out(0, 20, "mul");
    cs_high(0);

    // replay stored C
    cs_low(0);
    send_byte(0, 8'h30);
    wait_oe(0, "replay_oe");
    push_model(2, 5);
    read_out(0, 20, "replay");
    cs_high(0);

    // reuse A with B = identity
    mb[0] = 1; mb[1] = 0; mb[2] = 0; mb[3] = 1;
    cs_low(0);
    send_byte(0, 8'h20);
    send_mat(0, 2, 2, 1);
    wait_oe(0, "reuse_oe");
    push_model(2, 5);
    read_out(0, 20, "reuse");
    cs_high(0);

    // full-scale operands, no truncation
    for (int i = 0; i < 4; i++) begin
      ma[i] = 255;
      mb[i] = 255;
    end
    cs_low(0);
    send_byte(0, 8'h10);
    send_mat(0, 2, 2, 0);
    send_mat(0, 2, 2, 1);
    wait_oe(0, "max_oe");
    push_model(2, 5);
    read_out(0, 20, "max");
    cs_high(0);

    // abort during A load, then 0x20 must be rejected
    cs_low(0);
    send_byte(0, 8'h10);
    send_elem(0, 8'h11, 2);
    send_elem(0, 8'h22, 2);
    send_elem(0, 8'h33, 2);
    check("abort_busy_pre", 32'(busy0), 32'd1);
    set_cs(0, 1'b1);
    wait_clk(4);
    check("abort_oe", 32'(oe0), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    wait_clk(4);
    cs_low(0);
    send_byte(0, 8'h20);
    for (int i = 0; i < 4; i++) begin
      send_nib(0, 1);
      check("reuse_rejected_oe", 32'(oe0), 32'd0);
    end
    wait_clk(20);
    check("reuse_rejected_oe_late", 32'(oe0), 32'd0);
    cs_high(0);

    // 3x3, 4-bit elements, 3-nibble results
    for (int i = 0; i < 9; i++) begin
      ma[i] = 15;
      mb[i] = 15;
    end
    cs_low(1);
    send_byte(1, 8'h10);
    send_mat(1, 3, 1, 0);
    send_mat(1, 3, 1, 1);
    wait_oe(1, "n3_oe");
    push_model(3, 3);
    read_out(1, 27, "n3");
    cs_high(1);

    // unknown command: nothing driven for the whole frame
    cs_low(1);
    send_byte(1, 8'h55);
    for (int i = 0; i < 6; i++) begin
      send_nib(1, i);
      check("unknown_oe", 32'(oe1), 32'd0);
    end
    cs_high(1);
    check("unknown_busy_after", 32'(busy1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
